// File: rtl/key_debounce_repeat.sv
// Push-button front end: two-flop synchroniser, ms-tick debounce and a per-key
// press / auto-repeat / long-press state machine.
module key_debounce_repeat #(
  parameter int                   NUM_KEYS        = 4,
  parameter int                   CLK_HZ          = 12000000,
  parameter int                   DEBOUNCE_MS     = 20,
  parameter int                   REPEAT_DELAY_MS = 600,
  parameter int                   REPEAT_RATE_MS  = 150,
  parameter int                   ACTIVE_LOW      = 1,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = {NUM_KEYS{1'b1}}
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam int PW       = $clog2(TICK_CYC) + 1;
  localparam int DW       = $clog2(DEBOUNCE_MS) + 1;
  localparam int HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int HW       = $clog2(HOLD_MAX) + 1;
  localparam logic [NUM_KEYS-1:0] RELEASED = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, raw_pressed;
  logic [NUM_KEYS-1:0] level_q, level_d, pulse_q, pulse_d, long_q, long_d;
  logic [DW-1:0]       db_q   [NUM_KEYS];
  logic [DW-1:0]       db_d   [NUM_KEYS];
  logic [HW-1:0]       hold_q [NUM_KEYS];
  logic [HW-1:0]       hold_d [NUM_KEYS];
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];

  always_comb begin
    tick        = (presc_q == PW'(TICK_CYC - 1));
    presc_d     = tick ? '0 : presc_q + 1'b1;
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    raw_pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    long_d  = long_q;
    db_d    = db_q;
    hold_d  = hold_q;
    state_d = state_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      // A level change needs DEBOUNCE_MS uninterrupted mismatching ticks.
      if (raw_pressed[i] == level_q[i]) begin
        db_d[i] = '0;
      end else if (tick) begin
        if (db_q[i] == DW'(DEBOUNCE_MS - 1)) begin
          level_d[i] = raw_pressed[i];
          db_d[i]    = '0;
        end else begin
          db_d[i] = db_q[i] + 1'b1;
        end
      end

      // Release wins over any repeat falling due in the same cycle.
      if (level_q[i] && !level_d[i]) begin
        state_d[i] = IDLE;
        long_d[i]  = 1'b0;
        hold_d[i]  = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (level_d[i]) begin
              pulse_d[i] = 1'b1;
              hold_d[i]  = '0;
              state_d[i] = HOLD;
            end
          end
          HOLD: begin
            // Masked keys park here with long set and the counter frozen.
            if (tick && !long_q[i]) begin
              if (hold_q[i] == HW'(REPEAT_DELAY_MS - 1)) begin
                long_d[i] = 1'b1;
                hold_d[i] = '0;
                if (REPEAT_MASK[i]) begin
                  pulse_d[i] = 1'b1;
                  state_d[i] = REPEAT;
                end
              end else begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if (hold_q[i] == HW'(REPEAT_RATE_MS - 1)) begin
                pulse_d[i] = 1'b1;
                hold_d[i]  = '0;
              end else begin
                hold_d[i] = hold_q[i] + 1'b1;
              end
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc_q <= '0;
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      level_q <= '0;
      pulse_q <= '0;
      long_q  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_q[i]    <= '0;
        hold_q[i]  <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      presc_q <= presc_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      long_q  <= long_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  assign key_level = level_q;
  assign key_pulse = pulse_q;
  assign key_long  = long_q;

endmodule
